// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt entry sequencer: synchronises irq lines, maintains mip, arbitrates,
// flushes the pipeline and commits mepc/mcause. Define IRQ_VECTORED_EN for vectored trap_pc.
module irq_trap_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int FLUSH_MAX   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        sw_irq,
    input  logic [31:0] mip,
    output logic [31:0] mip_in,
    output logic        wr_mip,
    input  logic [31:0] mie,
    input  logic        mstatus_mie,
    input  logic [31:0] mtvec,
    input  logic        mret,
    input  logic [31:0] pc_resume,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        trap_take,
    output logic [31:0] trap_pc,
    output logic        wr_mepc,
    output logic [31:0] mepc_out,
    output logic        wr_mcause,
    output logic [31:0] mcause_out,
    output logic        irq_busy,
    output logic        irq_err
);

    localparam int CNT_W = $clog2(FLUSH_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        TRAP,
        SETTLE
    } state_t;

    logic [SYNC_STAGES-1:0] ext_sync_q, tmr_sync_q, sw_sync_q;
    logic                   s_ext, s_tmr, s_sw;

    state_t      state_q, state_d;
    logic [3:0]  code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        flush_req_q, flush_req_d;
    logic        trap_take_q, trap_take_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic        irq_err_q, irq_err_d;
    logic        irq_busy_q, irq_busy_d;
    logic        wr_mip_q, wr_mip_d;
    logic [31:0] mip_in_q, mip_in_d;

    logic [31:0] pend;
    logic        pend_any;
    logic [3:0]  arb_code;
    logic [31:0] trap_base;
    logic [31:0] trap_target;
    logic        unused_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync_q <= '0;
            tmr_sync_q <= '0;
            sw_sync_q  <= '0;
        end else begin
            ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_irq};
            tmr_sync_q <= {tmr_sync_q[SYNC_STAGES-2:0], timer_irq};
            sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], sw_irq};
        end
    end

    assign s_ext = ext_sync_q[SYNC_STAGES-1];
    assign s_tmr = tmr_sync_q[SYNC_STAGES-1];
    assign s_sw  = sw_sync_q[SYNC_STAGES-1];

    always_comb begin
        mip_in_d     = mip;
        mip_in_d[11] = s_ext;
        mip_in_d[7]  = s_tmr;
        mip_in_d[3]  = s_sw;
        wr_mip_d     = ({s_ext, s_tmr, s_sw} != {mip[11], mip[7], mip[3]});
    end

    // Fixed priority MEI > MSI > MTI, qualified by mie and the global enable.
    always_comb begin
        pend     = mip & mie & {32{mstatus_mie}};
        pend_any = pend[11] | pend[7] | pend[3];
        if (pend[11]) begin
            arb_code = 4'd11;
        end else if (pend[3]) begin
            arb_code = 4'd3;
        end else begin
            arb_code = 4'd7;
        end
    end

    assign trap_base = {mtvec[31:2], 2'b00};

`ifdef IRQ_VECTORED_EN
    assign trap_target = (mtvec[1:0] == 2'b01) ? (trap_base + {26'b0, code_q, 2'b00}) : trap_base;
`else
    assign trap_target = trap_base;
`endif

    assign unused_bits = ^{pend[31:12], pend[10:8], pend[6:4], pend[2:0], mtvec[1:0]};

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        flush_req_d = flush_req_q;
        trap_take_d = 1'b0;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        trap_pc_d   = trap_pc_q;
        irq_err_d   = irq_err_q;
        case (state_q)
            IDLE: begin
                if (pend_any && !mret) begin
                    code_d      = arb_code;
                    cnt_d       = '0;
                    flush_req_d = 1'b1;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                // Cause stays committed even if the pending bit drops while draining.
                if (flush_ack) begin
                    mepc_d      = pc_resume;
                    mcause_d    = {1'b1, 27'b0, code_q};
                    trap_pc_d   = trap_target;
                    flush_req_d = 1'b0;
                    trap_take_d = 1'b1;
                    state_d     = TRAP;
                end else if (cnt_q == CNT_W'(FLUSH_MAX - 1)) begin
                    flush_req_d = 1'b0;
                    irq_err_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TRAP: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                flush_req_d = 1'b0;
            end
        endcase
        irq_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            code_q      <= '0;
            cnt_q       <= '0;
            flush_req_q <= 1'b0;
            trap_take_q <= 1'b0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            trap_pc_q   <= '0;
            irq_err_q   <= 1'b0;
            irq_busy_q  <= 1'b0;
            wr_mip_q    <= 1'b0;
            mip_in_q    <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            flush_req_q <= flush_req_d;
            trap_take_q <= trap_take_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            trap_pc_q   <= trap_pc_d;
            irq_err_q   <= irq_err_d;
            irq_busy_q  <= irq_busy_d;
            wr_mip_q    <= wr_mip_d;
            mip_in_q    <= mip_in_d;
        end
    end

    assign mip_in     = mip_in_q;
    assign wr_mip     = wr_mip_q;
    assign flush_req  = flush_req_q;
    assign trap_take  = trap_take_q;
    assign wr_mepc    = trap_take_q;
    assign wr_mcause  = trap_take_q;
    assign trap_pc    = trap_pc_q;
    assign mepc_out   = mepc_q;
    assign mcause_out = mcause_q;
    assign irq_busy   = irq_busy_q;
    assign irq_err    = irq_err_q;

endmodule
